// File: rtl/pe_unary_mac_lanes.sv
// Multi-lane unary/stochastic MAC processing element: per-lane +/-1 accumulation,
// lane reduction, upstream partial-sum join and handshaked drain downstream.
module pe_unary_mac_lanes #(
    parameter int LANES      = 4,
    parameter int W_ABS_W    = 7,
    parameter int RAND_W     = 7,
    parameter int ACC_W      = 16,
    parameter int CNT_W      = 8,
    parameter int CHAIN_HEAD = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_W-1:0]           len,
    input  logic                       w_load,
    input  logic [LANES*W_ABS_W-1:0]   w_abs,
    input  logic [LANES-1:0]           w_sign,
    output logic [LANES*W_ABS_W-1:0]   w_abs_q,
    output logic [LANES-1:0]           w_sign_q,
    input  logic                       in_valid,
    input  logic [LANES-1:0]           in_abs,
    input  logic [LANES-1:0]           in_sign,
    input  logic [RAND_W-1:0]          rand_w,
    output logic                       in_valid_q,
    output logic [LANES-1:0]           in_abs_q,
    output logic [LANES-1:0]           in_sign_q,
    output logic [RAND_W-1:0]          rand_w_q,
    input  logic                       psum_in_valid,
    input  logic [ACC_W-1:0]           psum_in,
    output logic                       psum_in_ready,
    output logic                       psum_out_valid,
    output logic [ACC_W-1:0]           psum_out,
    input  logic                       psum_out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       sat
);

    localparam int CMP_W = (W_ABS_W > RAND_W) ? W_ABS_W : RAND_W;
    // Wide enough for a full lane reduction and for the join of two ACC_W values.
    localparam int SUM_W = ACC_W + $clog2(LANES) + 1;
    localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_REDUCE, S_JOIN, S_DRAIN} state_t;
    state_t state_reg, state_next;

    logic [CNT_W-1:0]         len_reg, cnt_reg;
    logic [ACC_W-1:0]         total_reg;
    logic                     sat_reg, done_reg;
    logic [LANES*W_ABS_W-1:0] w_abs_reg;
    logic [LANES-1:0]         w_sign_reg;
    logic                     fwd_valid_reg;
    logic [LANES-1:0]         fwd_abs_reg, fwd_sign_reg;
    logic [RAND_W-1:0]        fwd_rand_reg;

    logic [LANES-1:0][ACC_W-1:0] acc_all;
    logic [LANES-1:0]            lane_ovf;
    logic signed [SUM_W-1:0]     red_sum, jn_sum;
    logic                        start_acc, drain_xfer, join_xfer, beat, last_beat;

    function automatic logic signed [SUM_W-1:0] sx(input logic [ACC_W-1:0] a);
        return {{(SUM_W-ACC_W){a[ACC_W-1]}}, a};
    endfunction

    function automatic logic sum_ovf(input logic signed [SUM_W-1:0] v);
        return (v > SUM_MAX) || (v < SUM_MIN);
    endfunction

    function automatic logic [ACC_W-1:0] sum_clamp(input logic signed [SUM_W-1:0] v);
        logic [ACC_W-1:0] r;
        if (v > SUM_MAX)      r = SUM_MAX[ACC_W-1:0];
        else if (v < SUM_MIN) r = SUM_MIN[ACC_W-1:0];
        else                  r = v[ACC_W-1:0];
        return r;
    endfunction

    assign start_acc  = (state_reg == S_IDLE) && start;
    assign drain_xfer = (state_reg == S_DRAIN) && psum_out_ready;
    assign join_xfer  = (state_reg == S_JOIN) && (CHAIN_HEAD == 0) && psum_in_valid;
    assign beat       = (state_reg == S_RUN) && in_valid;
    assign last_beat  = beat && (cnt_reg == len_reg - CNT_W'(1));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CMP_W-1:0]        w_mag, r_mag;
            logic                    u_w, m_bit, s_bit;
            logic signed [SUM_W-1:0] acc_step;
            logic [ACC_W-1:0]        acc_reg;

            assign w_mag    = CMP_W'(w_abs_reg[gi*W_ABS_W +: W_ABS_W]);
            assign r_mag    = CMP_W'(rand_w);
            assign u_w      = w_mag > r_mag;
            assign m_bit    = in_abs[gi] & u_w;
            assign s_bit    = in_sign[gi] ^ w_sign_reg[gi];
            assign acc_step = s_bit ? sx(acc_reg) - SUM_W'(1) : sx(acc_reg) + SUM_W'(1);
            assign lane_ovf[gi] = beat && m_bit && sum_ovf(acc_step);
            assign acc_all[gi]  = acc_reg;

            always_ff @(posedge clk) begin
                if (reset || start_acc || drain_xfer)
                    acc_reg <= '0;
                else if (beat && m_bit)
                    acc_reg <= sum_clamp(acc_step);
            end
        end
    endgenerate

    always_comb begin
        red_sum = '0;
        for (int i = 0; i < LANES; i++)
            red_sum = red_sum + sx(acc_all[i]);
    end

    assign jn_sum = sx(total_reg) + sx(psum_in);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = (len == '0) ? S_REDUCE : S_RUN;
            S_RUN:    if (last_beat) state_next = S_REDUCE;
            S_REDUCE: state_next = S_JOIN;
            S_JOIN:   if (CHAIN_HEAD != 0 || psum_in_valid) state_next = S_DRAIN;
            S_DRAIN:  if (psum_out_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_reg != S_IDLE);
        psum_in_ready  = (state_reg == S_JOIN) && (CHAIN_HEAD == 0);
        psum_out_valid = (state_reg == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg    <= '0;
            cnt_reg    <= '0;
            total_reg  <= '0;
            sat_reg    <= 1'b0;
            done_reg   <= 1'b0;
            w_abs_reg  <= '0;
            w_sign_reg <= '0;
        end else begin
            if (start_acc) begin
                len_reg   <= len;
                cnt_reg   <= '0;
                total_reg <= '0;
                sat_reg   <= 1'b0;
            end else begin
                if (beat) cnt_reg <= cnt_reg + CNT_W'(1);
                if (state_reg == S_REDUCE)
                    total_reg <= sum_clamp(red_sum);
                else if (join_xfer)
                    total_reg <= sum_clamp(jn_sum);
                sat_reg <= sat_reg | (|lane_ovf)
                         | ((state_reg == S_REDUCE) && sum_ovf(red_sum))
                         | (join_xfer && sum_ovf(jn_sum));
            end
            if ((state_reg == S_IDLE) && w_load) begin
                w_abs_reg  <= w_abs;
                w_sign_reg <= w_sign;
            end
            done_reg <= drain_xfer;
        end
    end

    // Neighbour copies of the input stream, registered unconditionally.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_valid_reg <= 1'b0;
            fwd_abs_reg   <= '0;
            fwd_sign_reg  <= '0;
            fwd_rand_reg  <= '0;
        end else begin
            fwd_valid_reg <= in_valid;
            fwd_abs_reg   <= in_abs;
            fwd_sign_reg  <= in_sign;
            fwd_rand_reg  <= rand_w;
        end
    end

    assign w_abs_q    = w_abs_reg;
    assign w_sign_q   = w_sign_reg;
    assign in_valid_q = fwd_valid_reg;
    assign in_abs_q   = fwd_abs_reg;
    assign in_sign_q  = fwd_sign_reg;
    assign rand_w_q   = fwd_rand_reg;
    assign psum_out   = total_reg;
    assign done       = done_reg;
    assign sat        = sat_reg;

endmodule

// File: tb/tb_pe_unary_mac_lanes.sv
// Directed bench for pe_unary_mac_lanes: a chain-head, a joining and a narrow
// (8-bit) instance share one stimulus stream.
module tb_pe_unary_mac_lanes;

    logic        clk = 1'b0;
    logic        reset, start, w_load, in_valid, psum_in_valid, psum_out_ready;
    logic [7:0]  len;
    logic [27:0] w_abs;
    logic [3:0]  w_sign, in_abs, in_sign;
    logic [6:0]  rand_w;
    logic [15:0] psum_in;

    logic [27:0] h_w_abs_q, j_w_abs_q, s_w_abs_q;
    logic [3:0]  h_w_sign_q, j_w_sign_q, s_w_sign_q;
    logic        h_in_valid_q, j_in_valid_q, s_in_valid_q;
    logic [3:0]  h_in_abs_q, j_in_abs_q, s_in_abs_q;
    logic [3:0]  h_in_sign_q, j_in_sign_q, s_in_sign_q;
    logic [6:0]  h_rand_w_q, j_rand_w_q, s_rand_w_q;
    logic        h_psum_in_ready, j_psum_in_ready, s_psum_in_ready;
    logic        h_psum_out_valid, j_psum_out_valid, s_psum_out_valid;
    logic [15:0] h_psum_out, j_psum_out;
    logic [7:0]  s_psum_out;
    logic        h_busy, j_busy, s_busy, h_done, j_done, s_done, h_sat, j_sat, s_sat;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    pe_unary_mac_lanes #(.LANES(4), .W_ABS_W(7), .RAND_W(7), .ACC_W(16), .CNT_W(8), .CHAIN_HEAD(1)) dut_h (
        .clk(clk), .reset(reset), .start(start), .len(len), .w_load(w_load), .w_abs(w_abs), .w_sign(w_sign),
        .w_abs_q(h_w_abs_q), .w_sign_q(h_w_sign_q), .in_valid(in_valid), .in_abs(in_abs), .in_sign(in_sign),
        .rand_w(rand_w), .in_valid_q(h_in_valid_q), .in_abs_q(h_in_abs_q), .in_sign_q(h_in_sign_q),
        .rand_w_q(h_rand_w_q), .psum_in_valid(psum_in_valid), .psum_in(psum_in), .psum_in_ready(h_psum_in_ready),
        .psum_out_valid(h_psum_out_valid), .psum_out(h_psum_out), .psum_out_ready(psum_out_ready),
        .busy(h_busy), .done(h_done), .sat(h_sat));

    pe_unary_mac_lanes #(.LANES(4), .W_ABS_W(7), .RAND_W(7), .ACC_W(16), .CNT_W(8), .CHAIN_HEAD(0)) dut_j (
        .clk(clk), .reset(reset), .start(start), .len(len), .w_load(w_load), .w_abs(w_abs), .w_sign(w_sign),
        .w_abs_q(j_w_abs_q), .w_sign_q(j_w_sign_q), .in_valid(in_valid), .in_abs(in_abs), .in_sign(in_sign),
        .rand_w(rand_w), .in_valid_q(j_in_valid_q), .in_abs_q(j_in_abs_q), .in_sign_q(j_in_sign_q),
        .rand_w_q(j_rand_w_q), .psum_in_valid(psum_in_valid), .psum_in(psum_in), .psum_in_ready(j_psum_in_ready),
        .psum_out_valid(j_psum_out_valid), .psum_out(j_psum_out), .psum_out_ready(psum_out_ready),
        .busy(j_busy), .done(j_done), .sat(j_sat));

    pe_unary_mac_lanes #(.LANES(4), .W_ABS_W(7), .RAND_W(7), .ACC_W(8), .CNT_W(8), .CHAIN_HEAD(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .len(len), .w_load(w_load), .w_abs(w_abs), .w_sign(w_sign),
        .w_abs_q(s_w_abs_q), .w_sign_q(s_w_sign_q), .in_valid(in_valid), .in_abs(in_abs), .in_sign(in_sign),
        .rand_w(rand_w), .in_valid_q(s_in_valid_q), .in_abs_q(s_in_abs_q), .in_sign_q(s_in_sign_q),
        .rand_w_q(s_rand_w_q), .psum_in_valid(psum_in_valid), .psum_in(psum_in[7:0]), .psum_in_ready(s_psum_in_ready),
        .psum_out_valid(s_psum_out_valid), .psum_out(s_psum_out), .psum_out_ready(psum_out_ready),
        .busy(s_busy), .done(s_done), .sat(s_sat));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; len = 0; w_load = 0; w_abs = '0; w_sign = '0;
        in_valid = 0; in_abs = '0; in_sign = '0; rand_w = '0;
        psum_in_valid = 0; psum_in = '0; psum_out_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; tick(); reset = 0; tick();
    endtask

    task automatic load_w(input logic [6:0] mag, input logic [3:0] sg);
        w_abs = {4{mag}}; w_sign = sg; w_load = 1; tick(); w_load = 0;
    endtask

    // rmode 0: rand_w counts 0,1,2..; rmode 1: rand_w held at 0. Returns in REDUCE.
    task automatic run_stream(input int n, input int rmode);
        start = 1; len = n[7:0]; tick(); start = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1;
            rand_w = (rmode != 0) ? 7'd0 : i[6:0];
            tick();
        end
        in_valid = 0;
    endtask

    task automatic drain();
        psum_out_ready = 1; tick(); psum_out_ready = 0;
    endtask

    task automatic wait_valid(input int which, input int max, output int n);
        n = 0;
        while (n < max && !((which == 0 && h_psum_out_valid) || (which == 1 && j_psum_out_valid) ||
                            (which == 2 && s_psum_out_valid))) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        start = 1; len = 8'd5; w_load = 1; w_abs = '1; w_sign = '1; in_valid = 1; in_abs = '1;
        in_sign = '1; rand_w = '1; psum_in_valid = 1; psum_out_ready = 1;
        reset = 1; tick();
        total_cnt++; if (h_busy !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy: got %0b want 0", h_busy); end
        total_cnt++; if (h_done !== 1'b0 || h_sat !== 1'b0) begin bad_cnt++; $display("FAIL reset_done_sat: got %0b%0b want 00", h_done, h_sat); end
        total_cnt++; if (h_psum_out !== 16'd0 || h_psum_out_valid !== 1'b0) begin bad_cnt++; $display("FAIL reset_psum_out: got %0d/%0b want 0/0", h_psum_out, h_psum_out_valid); end
        total_cnt++; if (j_psum_in_ready !== 1'b0) begin bad_cnt++; $display("FAIL reset_in_ready: got %0b want 0", j_psum_in_ready); end
        total_cnt++; if (h_in_valid_q !== 1'b0 || h_in_abs_q !== 4'd0 || h_in_sign_q !== 4'd0 || h_rand_w_q !== 7'd0) begin
            bad_cnt++; $display("FAIL reset_fwd: got %0b %h %h %h want 0 0 0 0", h_in_valid_q, h_in_abs_q, h_in_sign_q, h_rand_w_q); end
        total_cnt++; if (h_w_abs_q !== 28'd0 || h_w_sign_q !== 4'd0) begin bad_cnt++; $display("FAIL reset_weights: got %h %h want 0 0", h_w_abs_q, h_w_sign_q); end
        clear_inputs(); reset = 0; tick();
    endtask

    task automatic test_forwarding();
        logic [27:0] exp_w;
        do_reset();
        in_valid = 1; in_abs = 4'hA; in_sign = 4'h5; rand_w = 7'h55; tick();
        total_cnt++; if (h_in_valid_q !== 1'b1 || h_in_abs_q !== 4'hA || h_in_sign_q !== 4'h5 || h_rand_w_q !== 7'h55) begin
            bad_cnt++; $display("FAIL fwd_1: got %0b %h %h %h want 1 a 5 55", h_in_valid_q, h_in_abs_q, h_in_sign_q, h_rand_w_q); end
        in_valid = 0; in_abs = 4'h3; tick();
        total_cnt++; if (h_in_valid_q !== 1'b0 || h_in_abs_q !== 4'h3) begin bad_cnt++; $display("FAIL fwd_2: got %0b %h want 0 3", h_in_valid_q, h_in_abs_q); end
        exp_w = {7'd4, 7'd3, 7'd2, 7'd1};
        w_abs = exp_w; w_sign = 4'b1010; tick();
        total_cnt++; if (h_w_abs_q !== 28'd0) begin bad_cnt++; $display("FAIL w_no_load: got %h want 0", h_w_abs_q); end
        w_load = 1; tick(); w_load = 0;
        total_cnt++; if (h_w_abs_q !== exp_w || h_w_sign_q !== 4'b1010) begin bad_cnt++; $display("FAIL w_load: got %h %b want %h 1010", h_w_abs_q, h_w_sign_q, exp_w); end
    endtask

    task automatic test_basic_count();
        do_reset(); load_w(7'd100, 4'b0000);
        in_abs = 4'hF; in_sign = 4'h0;
        run_stream(128, 0);
        total_cnt++; if (h_busy !== 1'b1 || h_psum_out_valid !== 1'b0) begin bad_cnt++; $display("FAIL basic_reduce: got busy %0b valid %0b want 1 0", h_busy, h_psum_out_valid); end
        tick();
        total_cnt++; if (h_psum_in_ready !== 1'b0 || h_psum_out_valid !== 1'b0) begin bad_cnt++; $display("FAIL basic_join: got ready %0b valid %0b want 0 0", h_psum_in_ready, h_psum_out_valid); end
        tick();
        total_cnt++; if (h_psum_out_valid !== 1'b1) begin bad_cnt++; $display("FAIL basic_drain_latency: got valid %0b want 1", h_psum_out_valid); end
        total_cnt++; if (h_psum_out !== 16'd400) begin bad_cnt++; $display("FAIL basic_psum: got %0d want 400", $signed(h_psum_out)); end
        total_cnt++; if (h_sat !== 1'b0) begin bad_cnt++; $display("FAIL basic_sat: got %0b want 0", h_sat); end
        total_cnt++; if (h_done !== 1'b0) begin bad_cnt++; $display("FAIL basic_done_early: got %0b want 0", h_done); end
        drain();
        total_cnt++; if (h_done !== 1'b1 || h_busy !== 1'b0) begin bad_cnt++; $display("FAIL basic_done: got done %0b busy %0b want 1 0", h_done, h_busy); end
        tick();
        total_cnt++; if (h_done !== 1'b0) begin bad_cnt++; $display("FAIL basic_done_pulse: got %0b want 0", h_done); end
    endtask

    task automatic test_signs();
        int n;
        do_reset(); load_w(7'd100, 4'b0010);
        in_abs = 4'hF; in_sign = 4'b0001;
        run_stream(128, 0);
        wait_valid(0, 10, n);
        total_cnt++; if (n != 2) begin bad_cnt++; $display("FAIL signs_latency: got %0d want 2", n); end
        total_cnt++; if (h_psum_out !== 16'd0) begin bad_cnt++; $display("FAIL signs_psum: got %0d want 0", $signed(h_psum_out)); end
        drain();
        load_w(7'd100, 4'b0000);
        in_sign = 4'b0111;
        run_stream(128, 0);
        wait_valid(0, 10, n);
        total_cnt++; if (h_psum_out !== 16'hFF38) begin bad_cnt++; $display("FAIL signs_neg: got %0d want -200", $signed(h_psum_out)); end
        drain();
    endtask

    task automatic test_join_backpressure();
        do_reset(); load_w(7'd100, 4'b0000);
        in_abs = 4'hF; in_sign = 4'h0;
        psum_in_valid = 1; psum_in = 16'd1000;
        run_stream(128, 0);
        psum_in_valid = 0;
        total_cnt++; if (j_psum_in_ready !== 1'b0) begin bad_cnt++; $display("FAIL join_ready_reduce: got %0b want 0", j_psum_in_ready); end
        tick();
        for (int k = 0; k < 6; k++) begin
            total_cnt++; if (j_psum_in_ready !== 1'b1 || j_psum_out_valid !== 1'b0) begin
                bad_cnt++; $display("FAIL join_wait_%0d: got ready %0b valid %0b want 1 0", k, j_psum_in_ready, j_psum_out_valid); end
            if (k == 5) begin psum_in_valid = 1; psum_in = 16'hFFCE; end
            tick();
        end
        psum_in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (j_psum_out_valid !== 1'b1 || j_psum_out !== 16'd350 || j_psum_in_ready !== 1'b0) begin
                bad_cnt++; $display("FAIL join_drain_%0d: got valid %0b psum %0d ready %0b want 1 350 0", k, j_psum_out_valid, $signed(j_psum_out), j_psum_in_ready); end
            if (k == 3) psum_out_ready = 1;
            tick();
        end
        psum_out_ready = 0;
        total_cnt++; if (j_done !== 1'b1 || j_psum_out_valid !== 1'b0) begin bad_cnt++; $display("FAIL join_done: got done %0b valid %0b want 1 0", j_done, j_psum_out_valid); end
    endtask

    task automatic test_saturation();
        int n;
        do_reset(); load_w(7'd127, 4'b0000);
        in_abs = 4'hF; in_sign = 4'h0;
        run_stream(200, 1);
        wait_valid(2, 10, n);
        total_cnt++; if (n != 2) begin bad_cnt++; $display("FAIL sat_latency: got %0d want 2", n); end
        total_cnt++; if (s_psum_out !== 8'h7F) begin bad_cnt++; $display("FAIL sat_total: got %0d want 127", $signed(s_psum_out)); end
        total_cnt++; if (s_sat !== 1'b1) begin bad_cnt++; $display("FAIL sat_flag: got %0b want 1", s_sat); end
        total_cnt++; if (h_psum_out !== 16'd800 || h_sat !== 1'b0) begin bad_cnt++; $display("FAIL sat_wide: got %0d sat %0b want 800 0", $signed(h_psum_out), h_sat); end
        drain();
        total_cnt++; if (s_sat !== 1'b1) begin bad_cnt++; $display("FAIL sat_sticky: got %0b want 1", s_sat); end
        start = 1; len = 8'd0; tick(); start = 0;
        total_cnt++; if (s_sat !== 1'b0) begin bad_cnt++; $display("FAIL sat_clear: got %0b want 0", s_sat); end
        tick(); tick(); drain();
    endtask

    task automatic test_reset_mid_run();
        int n;
        do_reset(); load_w(7'd100, 4'b0000);
        in_abs = 4'hF; in_sign = 4'h0;
        start = 1; len = 8'd128; tick(); start = 0;
        for (int i = 0; i < 10; i++) begin in_valid = 1; rand_w = i[6:0]; tick(); end
        reset = 1; tick();
        total_cnt++; if (h_busy !== 1'b0 || h_psum_out_valid !== 1'b0 || h_psum_out !== 16'd0 || h_done !== 1'b0) begin
            bad_cnt++; $display("FAIL midreset_state: got busy %0b valid %0b psum %0d done %0b want 0 0 0 0", h_busy, h_psum_out_valid, h_psum_out, h_done); end
        total_cnt++; if (h_in_valid_q !== 1'b0 || h_w_abs_q !== 28'd0) begin bad_cnt++; $display("FAIL midreset_fwd: got %0b %h want 0 0", h_in_valid_q, h_w_abs_q); end
        reset = 0; in_valid = 0; tick();
        total_cnt++; if (h_done !== 1'b0) begin bad_cnt++; $display("FAIL midreset_no_done: got %0b want 0", h_done); end
        load_w(7'd100, 4'b0000);
        run_stream(4, 0);
        wait_valid(0, 10, n);
        total_cnt++; if (n != 2 || h_psum_out !== 16'd16) begin bad_cnt++; $display("FAIL midreset_rerun: got %0d after %0d want 16 after 2", $signed(h_psum_out), n); end
        drain();
        total_cnt++; if (h_done !== 1'b1) begin bad_cnt++; $display("FAIL midreset_done: got %0b want 1", h_done); end
    endtask

    task automatic test_edges();
        int n;
        do_reset(); load_w(7'd100, 4'b0000);
        in_abs = 4'hF; in_sign = 4'h0;
        start = 1; len = 8'd8; tick(); start = 0;
        for (int b = 0; b < 8; b++) begin
            if (b == 3 || b == 5) begin in_valid = 0; rand_w = 7'd0; tick(); end
            in_valid = 1; rand_w = b[6:0];
            if (b == 2) begin w_load = 1; w_abs = '0; start = 1; len = 8'd2; end
            tick();
            w_load = 0; start = 0;
        end
        in_valid = 0;
        total_cnt++; if (h_w_abs_q !== {4{7'd100}}) begin bad_cnt++; $display("FAIL edge_wload_ignored: got %h want all 100", h_w_abs_q); end
        wait_valid(0, 10, n);
        total_cnt++; if (n != 2) begin bad_cnt++; $display("FAIL edge_gap_latency: got %0d want 2", n); end
        total_cnt++; if (h_psum_out !== 16'd32) begin bad_cnt++; $display("FAIL edge_gap_psum: got %0d want 32", $signed(h_psum_out)); end
        drain();
        start = 1; len = 8'd0; tick(); start = 0;
        total_cnt++; if (h_busy !== 1'b1 || h_psum_out_valid !== 1'b0) begin bad_cnt++; $display("FAIL edge_len0_t1: got busy %0b valid %0b want 1 0", h_busy, h_psum_out_valid); end
        tick(); tick();
        total_cnt++; if (h_psum_out_valid !== 1'b1 || h_psum_out !== 16'd0) begin bad_cnt++; $display("FAIL edge_len0_t3: got valid %0b psum %0d want 1 0", h_psum_out_valid, $signed(h_psum_out)); end
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forwarding();
        test_basic_count();
        test_signs();
        test_join_backpressure();
        test_saturation();
        test_reset_mid_run();
        test_edges();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
